// File: rtl/imem_loader_if.sv
// Signal bundle between the boot stream host, the program loader,
// the instruction-memory write port and the core reset line.
interface imem_loader_if #(
  parameter int XLEN    = 32,
  parameter int PC_BITS = 5
) ();
  logic               start;
  logic [PC_BITS-1:0] base;
  logic [PC_BITS:0]   len;
  logic               s_valid;
  logic [XLEN-1:0]    s_data;
  logic               s_ready;
  logic               imem_we;
  logic [PC_BITS-1:0] imem_addr;
  logic [XLEN-1:0]    imem_wdata;
  logic               cpu_rst;
  logic               busy;
  logic               done;
  logic               err;
  logic [XLEN-1:0]    checksum;

  modport master (
    output start, base, len, s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err, checksum
  );

  modport slave (
    input  start, base, len, s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err, checksum
  );
endinterface

// File: rtl/imem_loader.sv
// Streams program words into consecutive instruction-memory addresses and
// keeps the core in reset until a complete program has been written.
module imem_loader #(
  parameter int XLEN    = 32,
  parameter int PC_BITS = 5
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  localparam logic [PC_BITS:0] DEPTH_W = {1'b1, {PC_BITS{1'b0}}};
  localparam logic [PC_BITS:0] ONE_W   = {{PC_BITS{1'b0}}, 1'b1};

  // Over-range lengths fill the whole memory exactly once.
  function automatic logic [PC_BITS:0] sat_len(input logic [PC_BITS:0] l);
    if (l > DEPTH_W) begin
      sat_len = DEPTH_W;
    end else begin
      sat_len = l;
    end
  endfunction

  state_e             state_q, state_d;
  logic [PC_BITS-1:0] base_q, base_d;
  logic [PC_BITS:0]   len_q, len_d;
  logic [PC_BITS:0]   count_q, count_d;
  logic               we_q, we_d;
  logic [PC_BITS-1:0] addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [XLEN-1:0]    csum_q, csum_d;
  logic               released_q, released_d;
  logic               beat_s;
  logic               busy_s;

  assign beat_s = (state_q == S_LOAD) & bus.s_valid;
  assign busy_s = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= {PC_BITS{1'b0}};
      len_q      <= {(PC_BITS+1){1'b0}};
      count_q    <= {(PC_BITS+1){1'b0}};
      we_q       <= 1'b0;
      addr_q     <= {PC_BITS{1'b0}};
      wdata_q    <= {XLEN{1'b0}};
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      csum_q     <= {XLEN{1'b0}};
      released_q <= 1'b0;
    end else begin
      base_q     <= base_d;
      len_q      <= len_d;
      count_q    <= count_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      csum_q     <= csum_d;
      released_q <= released_d;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    count_d    = count_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = err_q;
    csum_d     = csum_q;
    released_d = released_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          csum_d     = {XLEN{1'b0}};
          released_d = 1'b0;
          if (bus.len != {(PC_BITS+1){1'b0}}) begin
            base_d  = bus.base;
            len_d   = sat_len(bus.len);
            count_d = {(PC_BITS+1){1'b0}};
            err_d   = (bus.len > DEPTH_W);
            state_d = S_LOAD;
          end else begin
            err_d   = 1'b0;
            state_d = S_FIN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        if (beat_s) begin
          we_d    = 1'b1;
          addr_d  = base_q + count_q[PC_BITS-1:0];
          wdata_d = bus.s_data;
          csum_d  = csum_q ^ bus.s_data;
          count_d = count_q + ONE_W;
          // count_d equals len on the final word of the session.
          if (count_d == len_q) begin
            state_d = S_FIN;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end

      S_FIN: begin
        done_d     = 1'b1;
        released_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // s_ready depends only on state so the host sees no path from s_valid.
  assign bus.s_ready    = (state_q == S_LOAD);
  assign bus.busy       = busy_s;
  assign bus.cpu_rst    = ~released_q | busy_s;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.checksum   = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: a timeline model of load sessions
// predicts every output each cycle, plus literal checks of key scenarios.
module tb_imem_loader;
  localparam int XLEN    = 32;
  localparam int PC_BITS = 5;
  localparam int DEPTH   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.XLEN(XLEN), .PC_BITS(PC_BITS)) bus ();
  imem_loader #(.XLEN(XLEN), .PC_BITS(PC_BITS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Inputs as the DUT saw them on the last rising edge.
  logic        smp_start, smp_valid;
  logic [4:0]  smp_base;
  logic [5:0]  smp_len;
  logic [31:0] smp_data;
  always @(posedge clk) begin
    smp_start <= bus.start;
    smp_valid <= bus.s_valid;
    smp_base  <= bus.base;
    smp_len   <= bus.len;
    smp_data  <= bus.s_data;
  end

  // Session model: where a session sits in time, which word is next,
  // and when its completion pulse is due.
  int          cyc = 0;
  bit          m_sess, m_load, m_rel, m_err;
  int          m_base, m_len, m_k, m_done_due, m_done_cyc;
  logic [31:0] m_csum;
  bit          e_we;
  int          e_addr;
  logic [31:0] e_data;
  int          n_wr = 0, n_done = 0, last_wr_cyc = 0, done_obs_cyc = 0;
  int          wlog[$];
  bit          idle_prev;

  always @(negedge clk) begin
    if (rst) begin
      m_sess = 0; m_load = 0; m_rel = 0; m_err = 0; m_csum = 0;
      m_k = 0; m_done_due = -10; m_done_cyc = -10; e_we = 0;
    end else begin
      cyc++;
      idle_prev = !m_sess;
      e_we = 0;
      if (m_sess && m_load && smp_valid) begin
        e_we   = 1;
        e_addr = (m_base + m_k) % DEPTH;
        e_data = smp_data;
        m_csum = m_csum ^ smp_data;
        m_k++;
        if (m_k == m_len) begin
          m_load = 0;
          m_done_due = cyc + 1;
        end
      end
      if (m_sess && cyc == m_done_due) begin
        m_sess = 0; m_rel = 1; m_done_cyc = cyc;
      end
      if (idle_prev && smp_start) begin
        m_sess = 1; m_rel = 0; m_csum = 0; m_k = 0;
        m_base = smp_base;
        m_len  = (smp_len > DEPTH) ? DEPTH : smp_len;
        m_err  = (smp_len > DEPTH);
        if (smp_len == 0) begin
          m_load = 0; m_done_due = cyc + 1;
        end else begin
          m_load = 1; m_done_due = -10;
        end
      end
    end
    chk("imem_we", bus.imem_we, e_we);
    if (e_we) begin
      chk("imem_addr", bus.imem_addr, e_addr);
      chk("imem_wdata", bus.imem_wdata, e_data);
    end
    chk("s_ready", bus.s_ready, m_sess && m_load);
    chk("busy", bus.busy, m_sess);
    chk("done", bus.done, !rst && (m_done_cyc == cyc));
    chk("cpu_rst", bus.cpu_rst, !m_rel || m_sess);
    chk("err", bus.err, m_err);
    chk("checksum", bus.checksum, m_csum);
    if (bus.imem_we) begin
      n_wr++; last_wr_cyc = cyc; wlog.push_back(int'(bus.imem_addr));
    end
    if (bus.done) begin
      n_done++; done_obs_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input int b, input int l);
    bus.start = 1'b1; bus.base = 5'(b); bus.len = 6'(l);
    tick();
    bus.start = 1'b0;
  endtask

  logic [31:0] dq[$];

  // mode 0: valid always, 1: pattern 1,0,0, 2: random. inj 1: random starts, 2: one start mid-load.
  task automatic run_session(input int b, input int l, input int mode, input int inj);
    int i = 0;
    do_start(b, l);
    while (m_sess && i < 400) begin
      case (mode)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = (i % 3 == 0);
        default: bus.s_valid = 1'($urandom_range(0, 1));
      endcase
      if (bus.s_valid && dq.size() > 0) bus.s_data = dq.pop_front();
      else bus.s_data = $urandom;
      bus.start = (inj == 1) ? ($urandom_range(0, 5) == 0) : (inj == 2 && i == 1);
      bus.base  = 5'($urandom_range(0, 31));
      bus.len   = 6'($urandom_range(1, 40));
      tick();
      i++;
    end
    bus.start = 1'b0; bus.s_valid = 1'b0;
    chk("session_timeout", m_sess, 0);
  endtask

  int w0, d0, l0;
  int exp_a[4];

  initial begin
    bus.start = 1'b0; bus.base = 5'd0; bus.len = 6'd0;
    bus.s_valid = 1'b0; bus.s_data = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_cpu_rst", bus.cpu_rst, 1);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_imem_we", bus.imem_we, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_checksum", bus.checksum, 32'h0);
    chk("rst_addr", bus.imem_addr, 0);

    // Continuous stream of four words at base 0.
    w0 = n_wr; d0 = n_done; l0 = wlog.size();
    dq = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_session(0, 4, 0, 0);
    chk("t2_writes", n_wr - w0, 4);
    chk("t2_dones", n_done - d0, 1);
    chk("t2_checksum", bus.checksum, 32'h44);
    chk("t2_done_now", bus.done, 1);
    chk("t2_cpu_rst", bus.cpu_rst, 0);
    chk("t2_done_gap", done_obs_cyc - last_wr_cyc, 1);
    for (int k = 0; k < 4; k++) chk("t2_addr", wlog[l0 + k], k);

    // Same load with a gappy stream.
    tick();
    w0 = n_wr; d0 = n_done; l0 = wlog.size();
    dq = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_session(0, 4, 1, 0);
    chk("t3_writes", n_wr - w0, 4);
    chk("t3_dones", n_done - d0, 1);
    chk("t3_checksum", bus.checksum, 32'h44);
    for (int k = 0; k < 4; k++) chk("t3_addr", wlog[l0 + k], k);

    // Address wrap.
    l0 = wlog.size();
    run_session(30, 4, 0, 0);
    exp_a = '{30, 31, 0, 1};
    for (int k = 0; k < 4; k++) chk("t4_addr", wlog[l0 + k], exp_a[k]);
    chk("t4_err", bus.err, 0);

    // Empty load, then over-range load.
    w0 = n_wr; d0 = n_done;
    run_session(7, 0, 0, 0);
    chk("t5_writes0", n_wr - w0, 0);
    chk("t5_dones0", n_done - d0, 1);
    chk("t5_cpu_rst0", bus.cpu_rst, 0);
    chk("t5_checksum0", bus.checksum, 32'h0);
    w0 = n_wr;
    do_start(3, 40);
    chk("t5_err", bus.err, 1);
    while (m_sess && n_wr - w0 < 40) begin
      bus.s_valid = 1'b1; bus.s_data = $urandom; tick();
    end
    bus.s_valid = 1'b0;
    repeat (2) tick();
    chk("t5_writes40", n_wr - w0, 32);
    chk("t5_busy40", bus.busy, 0);

    // Reset after the second of four beats.
    d0 = n_done;
    do_start(0, 4);
    bus.s_valid = 1'b1; bus.s_data = 32'hA1;
    @(posedge clk);
    @(negedge clk); bus.s_data = 32'hA2;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_we_rst", bus.imem_we, 0);
    chk("t6_cpu_rst", bus.cpu_rst, 1);
    tick();
    bus.s_valid = 1'b0;
    rst = 1'b0;
    repeat (4) tick();
    chk("t6_no_done", n_done - d0, 0);
    chk("t6_held", bus.cpu_rst, 1);

    // Start during LOAD is ignored.
    w0 = n_wr; l0 = wlog.size();
    run_session(5, 3, 1, 2);
    chk("t6_writes", n_wr - w0, 3);
    for (int k = 0; k < 3; k++) chk("t6_addr", wlog[l0 + k], 5 + k);

    // Random sessions, back-to-back starts on the done cycle.
    for (int s = 0; s < 12; s++) begin
      run_session($urandom_range(0, 31), $urandom_range(0, 40), 2, 1);
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
